inst_rom_loader: RTL and testbench

Instruction-memory responder for the CPU's instruction-fetch port. It serves the CPU's `rom_ce`/`rom_addr` requests with `rom_data` from an internal word array. That array is filled at boot from a byte stream, for example a UART receiver. While loading, the block holds the CPU core in reset and releases it once the final byte has been written. It sits between the external byte-load source and the core top level, replacing a fixed ROM.

---
 rtl/inst_rom_loader_if.sv | 23 ++
 rtl/inst_rom_loader.sv | 105 ++++++++++
 tb/tb_inst_rom_loader.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/inst_rom_loader_if.sv
// rtl/inst_rom_loader_if.sv - byte-load stream and instruction-fetch port bundle
interface inst_rom_loader_if;
    logic        ld_valid_i;
    logic [7:0]  ld_byte_i;
    logic        ld_last_i;
    logic        ld_ready_o;
    logic        reload_i;
    logic        rom_ce_i;
    logic [31:0] rom_addr_i;
    logic [31:0] rom_data_o;

    // Driven by the byte source and the core.
    modport master (
        output ld_valid_i, ld_byte_i, ld_last_i, reload_i, rom_ce_i, rom_addr_i,
        input  ld_ready_o, rom_data_o
    );

    // The loader itself.
    modport slave (
        input  ld_valid_i, ld_byte_i, ld_last_i, reload_i, rom_ce_i, rom_addr_i,
        output ld_ready_o, rom_data_o
    );
endinterface

// File: rtl/inst_rom_loader.sv
// rtl/inst_rom_loader.sv - boot-loaded instruction memory that holds the core in reset while loading
module inst_rom_loader #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    inst_rom_loader_if.slave      bus,
    output logic                  cpu_rst_o,
    output logic                  load_done_o,
    output logic [DEPTH_LOG2:0]   word_cnt_o,
    output logic                  ovf_o
);
    typedef enum logic {LOAD = 1'b0, RUN = 1'b1} state_t;

    localparam logic [DEPTH_LOG2:0] FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [31:0]   mem [0:(1 << DEPTH_LOG2) - 1];

    state_t        state;
    logic [1:0]    pos;
    logic [23:0]   asm_q;
    logic          ld_ready_q;

    logic          accept;
    logic          full;
    logic          word_end;
    logic          wr_en;
    logic [31:0]   wr_data;
    logic          addr_hit;
    logic [1:0]    unused_addr_bits;

    // Reload outranks byte accept; writes are blocked while reset is held.
    assign accept   = bus.ld_valid_i && ld_ready_q && !bus.reload_i;
    assign full     = (word_cnt_o == FULL);
    assign word_end = (pos == 2'd3) || bus.ld_last_i;
    assign wr_en    = rst && accept && word_end && !full;

    // Merge the incoming byte into the partial word; unfilled low bytes read as zero.
    always_comb begin
        wr_data = 32'h0;
        case (pos)
            2'd0:    wr_data = {bus.ld_byte_i, 24'h0};
            2'd1:    wr_data = {asm_q[23:16], bus.ld_byte_i, 16'h0};
            2'd2:    wr_data = {asm_q[23:8], bus.ld_byte_i, 8'h0};
            default: wr_data = {asm_q, bus.ld_byte_i};
        endcase
    end

    // Control state, counters and registered handshake/status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= LOAD;
            pos         <= 2'd0;
            asm_q       <= 24'h0;
            ld_ready_q  <= 1'b1;
            cpu_rst_o   <= 1'b1;
            load_done_o <= 1'b0;
            word_cnt_o  <= '0;
            ovf_o       <= 1'b0;
        end else if (bus.reload_i) begin
            state       <= LOAD;
            pos         <= 2'd0;
            asm_q       <= 24'h0;
            ld_ready_q  <= 1'b1;
            cpu_rst_o   <= 1'b1;
            load_done_o <= 1'b0;
            word_cnt_o  <= '0;
            ovf_o       <= 1'b0;
        end else if (accept) begin
            case (pos)
                2'd0:    asm_q[23:16] <= bus.ld_byte_i;
                2'd1:    asm_q[15:8]  <= bus.ld_byte_i;
                2'd2:    asm_q[7:0]   <= bus.ld_byte_i;
                default: asm_q        <= asm_q;
            endcase
            pos <= word_end ? 2'd0 : pos + 2'd1;
            if (full) begin
                ovf_o <= 1'b1;
            end else if (word_end) begin
                word_cnt_o <= word_cnt_o + 1'b1;
            end
            if (bus.ld_last_i) begin
                state       <= RUN;
                ld_ready_q  <= 1'b0;
                cpu_rst_o   <= 1'b0;
                load_done_o <= 1'b1;
            end
        end
    end

    // Array write port; contents survive reset and reload.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[word_cnt_o[DEPTH_LOG2-1:0]] <= wr_data;
        end
    end

    assign bus.ld_ready_o = ld_ready_q;

    // Zero-latency fetch, gated to RUN and to in-range addresses; otherwise a NOP.
    assign addr_hit         = (bus.rom_addr_i[31:DEPTH_LOG2+2] == '0);
    assign unused_addr_bits = bus.rom_addr_i[1:0];
    assign bus.rom_data_o   = (bus.rom_ce_i && (state == RUN) && addr_hit)
                            ? mem[bus.rom_addr_i[DEPTH_LOG2+1:2]] : 32'h0;
endmodule

// File: tb/tb_inst_rom_loader.sv
// tb/tb_inst_rom_loader.sv - directed self-checking bench for inst_rom_loader
module tb_inst_rom_loader;
    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_rst_a, load_done_a, ovf_a;
    logic [10:0] word_cnt_a;
    logic        cpu_rst_b, load_done_b, ovf_b;
    logic [2:0]  word_cnt_b;

    int tests_run = 0;
    int tests_failed = 0;

    inst_rom_loader_if bus_a ();
    inst_rom_loader_if bus_b ();

    inst_rom_loader #(.DEPTH_LOG2(10)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a),
        .cpu_rst_o(cpu_rst_a), .load_done_o(load_done_a),
        .word_cnt_o(word_cnt_a), .ovf_o(ovf_a)
    );

    inst_rom_loader #(.DEPTH_LOG2(2)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b),
        .cpu_rst_o(cpu_rst_b), .load_done_o(load_done_b),
        .word_cnt_o(word_cnt_b), .ovf_o(ovf_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [7:0] b, input logic last);
        bus_a.ld_valid_i = 1'b1;
        bus_a.ld_byte_i  = b;
        bus_a.ld_last_i  = last;
        tick();
        bus_a.ld_valid_i = 1'b0;
        bus_a.ld_last_i  = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] b, input logic last);
        bus_b.ld_valid_i = 1'b1;
        bus_b.ld_byte_i  = b;
        bus_b.ld_last_i  = last;
        tick();
        bus_b.ld_valid_i = 1'b0;
        bus_b.ld_last_i  = 1'b0;
    endtask

    task automatic read_a(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        bus_a.rom_ce_i   = 1'b1;
        bus_a.rom_addr_i = addr;
        #1;
        check(tag, bus_a.rom_data_o, exp);
        bus_a.rom_ce_i   = 1'b0;
    endtask

    task automatic read_b(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        bus_b.rom_ce_i   = 1'b1;
        bus_b.rom_addr_i = addr;
        #1;
        check(tag, bus_b.rom_data_o, exp);
        bus_b.rom_ce_i   = 1'b0;
    endtask

    task automatic pulse_reload_a();
        bus_a.reload_i = 1'b1;
        tick();
        bus_a.reload_i = 1'b0;
    endtask

    initial begin
        logic [7:0] img [8];
        img = '{8'h34, 8'h01, 8'h00, 8'h01, 8'h34, 8'h02, 8'h00, 8'h02};

        rst = 1'b0;
        bus_a.ld_valid_i = 0; bus_a.ld_byte_i = 0; bus_a.ld_last_i = 0;
        bus_a.reload_i = 0; bus_a.rom_ce_i = 0; bus_a.rom_addr_i = 0;
        bus_b.ld_valid_i = 0; bus_b.ld_byte_i = 0; bus_b.ld_last_i = 0;
        bus_b.reload_i = 0; bus_b.rom_ce_i = 0; bus_b.rom_addr_i = 0;

        // Reset state
        #12;
        check("rst_ready", {31'b0, bus_a.ld_ready_o}, 32'd1);
        check("rst_cpu_rst", {31'b0, cpu_rst_a}, 32'd1);
        check("rst_done", {31'b0, load_done_a}, 32'd0);
        check("rst_cnt", {21'b0, word_cnt_a}, 32'd0);
        check("rst_ovf", {31'b0, ovf_a}, 32'd0);
        tick();
        rst = 1'b1;

        // Full-word load, one byte per cycle
        for (int i = 0; i < 7; i++) send_a(img[i], 1'b0);
        check("full_cpu_rst_before_last", {31'b0, cpu_rst_a}, 32'd1);
        read_a("gate_load", 32'h0, 32'h0);
        send_a(img[7], 1'b1);
        check("full_cpu_rst_after_last", {31'b0, cpu_rst_a}, 32'd0);
        check("full_done", {31'b0, load_done_a}, 32'd1);
        check("full_ready", {31'b0, bus_a.ld_ready_o}, 32'd0);
        check("full_cnt", {21'b0, word_cnt_a}, 32'd2);
        read_a("full_rd0", 32'h0, 32'h34010001);
        read_a("full_rd4", 32'h4, 32'h34020002);
        read_a("full_rd5", 32'h5, 32'h34020002);

        // Gating in RUN
        bus_a.rom_ce_i = 1'b0; bus_a.rom_addr_i = 32'h0; #1;
        check("gate_ce0", bus_a.rom_data_o, 32'h0);
        read_a("gate_hiaddr", 32'h00010000, 32'h0);

        // Reload in RUN with a byte offered on the same edge
        bus_a.ld_valid_i = 1'b1; bus_a.ld_byte_i = 8'h99;
        pulse_reload_a();
        bus_a.ld_valid_i = 1'b0;
        check("reload_cpu_rst", {31'b0, cpu_rst_a}, 32'd1);
        check("reload_cnt", {21'b0, word_cnt_a}, 32'd0);
        check("reload_done", {31'b0, load_done_a}, 32'd0);
        check("reload_ready", {31'b0, bus_a.ld_ready_o}, 32'd1);
        read_a("gate_reload", 32'h0, 32'h0);

        // Partial final word
        send_a(8'hAA, 1'b0);
        send_a(8'hBB, 1'b1);
        check("part_cnt", {21'b0, word_cnt_a}, 32'd1);
        read_a("part_rd0", 32'h0, 32'hAABB0000);

        // Gapped stream
        pulse_reload_a();
        send_a(8'h11, 1'b0); tick();
        send_a(8'h22, 1'b0); tick();
        send_a(8'h33, 1'b0); tick();
        send_a(8'h44, 1'b1);
        check("gap_cnt", {21'b0, word_cnt_a}, 32'd1);
        read_a("gap_rd0", 32'h0, 32'h11223344);
        read_a("gap_rd4_kept", 32'h4, 32'h34020002);

        // Async reset mid-load, then a fresh load
        pulse_reload_a();
        send_a(8'hDE, 1'b0);
        send_a(8'hAD, 1'b0);
        #2 rst = 1'b0;
        #1;
        check("arst_cnt", {21'b0, word_cnt_a}, 32'd0);
        check("arst_cpu_rst", {31'b0, cpu_rst_a}, 32'd1);
        tick();
        rst = 1'b1;
        send_a(8'h01, 1'b0);
        send_a(8'h02, 1'b0);
        send_a(8'h03, 1'b0);
        send_a(8'h04, 1'b1);
        check("arst_reload_cnt", {21'b0, word_cnt_a}, 32'd1);
        read_a("arst_rd0", 32'h0, 32'h01020304);

        // Overflow on the 4-word instance
        for (int i = 0; i < 20; i++) send_b(8'(i), i == 19);
        check("ovf_cnt", {29'b0, word_cnt_b}, 32'd4);
        check("ovf_flag", {31'b0, ovf_b}, 32'd1);
        check("ovf_done", {31'b0, load_done_b}, 32'd1);
        read_b("ovf_rd0", 32'h0, 32'h00010203);
        read_b("ovf_rd4", 32'h4, 32'h04050607);
        read_b("ovf_rd8", 32'h8, 32'h08090A0B);
        read_b("ovf_rdC", 32'hC, 32'h0C0D0E0F);
        read_b("ovf_rd10_range", 32'h10, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
